// File: rtl/riscv_lsu_if.sv
// Data-memory port between the load/store unit (master) and data memory (slave).
// One request/response transaction: req held until gnt, then a single rvalid.
interface riscv_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        dmem_err;

  modport master (
    output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata, dmem_err
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata, dmem_err
  );
endinterface

// File: rtl/riscv_lsu.sv
// RISC-V load/store unit: one memory operation in flight, byte-lane formatting,
// misaligned/invalid/bus-error reporting with decode-stage cause codes.
module riscv_lsu (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        mem_op_i,
  input  logic [1:0]        mem_size_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  riscv_lsu_if.master       dmem,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic              lsu_exception_o,
  output logic [5:0]        lsu_exception_cause_o
);

  localparam logic [2:0] MEMORY_TYPE_NONE          = 3'd0;
  localparam logic [2:0] MEMORY_TYPE_LOAD          = 3'd1;
  localparam logic [2:0] MEMORY_TYPE_LOAD_UNSIGNED = 3'd2;
  localparam logic [2:0] MEMORY_TYPE_STORE         = 3'd3;

  localparam logic [1:0] MEMOP_SIZE_BYTE     = 2'd0;
  localparam logic [1:0] MEMOP_SIZE_HALFWORD = 2'd1;
  localparam logic [1:0] MEMOP_SIZE_WORD     = 2'd2;

  localparam logic [5:0] CSR_CAUSE_NONE               = 6'd0;
  localparam logic [5:0] CSR_CAUSE_INVALID_INSTR      = 6'd2;
  localparam logic [5:0] CSR_CAUSE_LOAD_MISALIGNED    = 6'd4;
  localparam logic [5:0] CSR_CAUSE_LOAD_ACCESS_FAULT  = 6'd5;
  localparam logic [5:0] CSR_CAUSE_STORE_MISALIGNED   = 6'd6;
  localparam logic [5:0] CSR_CAUSE_STORE_ACCESS_FAULT = 6'd7;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;

  logic        req_ready_d;
  logic        req_d, we_d;
  logic [3:0]  be_d;
  logic [31:0] daddr_d, dwdata_d;
  logic        resp_valid_d, exc_d;
  logic [31:0] resp_rdata_d;
  logic [5:0]  cause_d;

  logic        is_mem_op, is_store, bad_size, misaligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_rep;

  function automatic logic [31:0] fmt_load(input logic [2:0] op, input logic [1:0] size,
                                           input logic [1:0] off, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic        sx;
    b  = w[{off, 3'b000} +: 8];
    h  = off[1] ? w[31:16] : w[15:0];
    sx = (op == MEMORY_TYPE_LOAD);
    case (size)
      MEMOP_SIZE_BYTE:     fmt_load = {{24{sx & b[7]}}, b};
      MEMOP_SIZE_HALFWORD: fmt_load = {{16{sx & h[15]}}, h};
      default:             fmt_load = w;
    endcase
  endfunction

  assign is_mem_op  = (mem_op_i == MEMORY_TYPE_LOAD) || (mem_op_i == MEMORY_TYPE_LOAD_UNSIGNED) ||
                      (mem_op_i == MEMORY_TYPE_STORE);
  assign is_store   = (mem_op_i == MEMORY_TYPE_STORE);
  // Size encoding 3 is undefined and is reported like an invalid operation.
  assign bad_size   = (mem_size_i == 2'd3);
  assign misaligned = ((mem_size_i == MEMOP_SIZE_HALFWORD) && addr_i[0]) ||
                      ((mem_size_i == MEMOP_SIZE_WORD) && (addr_i[1:0] != 2'b00));

  always_comb begin
    case (mem_size_i)
      MEMOP_SIZE_BYTE: begin
        be_calc   = 4'b0001 << addr_i[1:0];
        wdata_rep = {4{wdata_i[7:0]}};
      end
      MEMOP_SIZE_HALFWORD: begin
        be_calc   = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_i[15:0]}};
      end
      default: begin
        be_calc   = 4'b1111;
        wdata_rep = wdata_i;
      end
    endcase
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    size_d       = size_q;
    off_d        = off_q;
    req_d        = 1'b0;
    we_d         = 1'b0;
    be_d         = 4'b0000;
    daddr_d      = 32'h0;
    dwdata_d     = 32'h0;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0;
    exc_d        = 1'b0;
    cause_d      = CSR_CAUSE_NONE;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          op_d   = mem_op_i;
          size_d = mem_size_i;
          off_d  = addr_i[1:0];
          if (mem_op_i == MEMORY_TYPE_NONE) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
          end else if (!is_mem_op || bad_size) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            exc_d        = 1'b1;
            cause_d      = CSR_CAUSE_INVALID_INSTR;
          end else if (misaligned) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            exc_d        = 1'b1;
            cause_d      = is_store ? CSR_CAUSE_STORE_MISALIGNED : CSR_CAUSE_LOAD_MISALIGNED;
          end else begin
            state_d  = REQ;
            req_d    = 1'b1;
            we_d     = is_store;
            be_d     = be_calc;
            daddr_d  = {addr_i[31:2], 2'b00};
            dwdata_d = is_store ? wdata_rep : 32'h0;
          end
        end
      end
      REQ: begin
        if (dmem.dmem_gnt) begin
          state_d = WAIT;
        end else begin
          req_d    = 1'b1;
          we_d     = dmem.dmem_we;
          be_d     = dmem.dmem_be;
          daddr_d  = dmem.dmem_addr;
          dwdata_d = dmem.dmem_wdata;
        end
      end
      WAIT: begin
        if (dmem.dmem_rvalid) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          if (dmem.dmem_err) begin
            exc_d   = 1'b1;
            cause_d = (op_q == MEMORY_TYPE_STORE) ? CSR_CAUSE_STORE_ACCESS_FAULT
                                                  : CSR_CAUSE_LOAD_ACCESS_FAULT;
          end else if (op_q != MEMORY_TYPE_STORE) begin
            resp_rdata_d = fmt_load(op_q, size_q, off_q, dmem.dmem_rdata);
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready_d = (state_d == IDLE);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q               <= IDLE;
      op_q                  <= MEMORY_TYPE_NONE;
      size_q                <= MEMOP_SIZE_BYTE;
      off_q                 <= 2'b00;
      req_ready_o           <= 1'b1;
      dmem.dmem_req         <= 1'b0;
      dmem.dmem_we          <= 1'b0;
      dmem.dmem_be          <= 4'b0000;
      dmem.dmem_addr        <= 32'h0;
      dmem.dmem_wdata       <= 32'h0;
      resp_valid_o          <= 1'b0;
      resp_rdata_o          <= 32'h0;
      lsu_exception_o       <= 1'b0;
      lsu_exception_cause_o <= CSR_CAUSE_NONE;
    end else begin
      state_q               <= state_d;
      op_q                  <= op_d;
      size_q                <= size_d;
      off_q                 <= off_d;
      req_ready_o           <= req_ready_d;
      dmem.dmem_req         <= req_d;
      dmem.dmem_we          <= we_d;
      dmem.dmem_be          <= be_d;
      dmem.dmem_addr        <= daddr_d;
      dmem.dmem_wdata       <= dwdata_d;
      resp_valid_o          <= resp_valid_d;
      resp_rdata_o          <= resp_rdata_d;
      lsu_exception_o       <= exc_d;
      lsu_exception_cause_o <= cause_d;
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed self-checking bench for riscv_lsu; memory side is driven by hand
// from the bench, all sampling and driving happens on the falling clock edge.
module tb_riscv_lsu;

  localparam logic [2:0] OP_NONE = 3'd0, OP_LOAD = 3'd1, OP_LOADU = 3'd2,
                         OP_STORE = 3'd3, OP_INVALID = 3'd4;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  mem_op;
  logic [1:0]  mem_size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        lsu_exception;
  logic [5:0]  lsu_exception_cause;

  int checks = 0;
  int errors = 0;

  riscv_lsu_if dmem_if ();

  riscv_lsu dut (
    .clk                   (clk),
    .rst                   (rst),
    .req_valid_i           (req_valid),
    .req_ready_o           (req_ready),
    .mem_op_i              (mem_op),
    .mem_size_i            (mem_size),
    .addr_i                (addr),
    .wdata_i               (wdata),
    .dmem                  (dmem_if.master),
    .resp_valid_o          (resp_valid),
    .resp_rdata_o          (resp_rdata),
    .lsu_exception_o       (lsu_exception),
    .lsu_exception_cause_o (lsu_exception_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    dmem_if.dmem_gnt    = 1'b0;
    dmem_if.dmem_rvalid = 1'b0;
    dmem_if.dmem_rdata  = 32'h0;
    dmem_if.dmem_err    = 1'b0;
  endtask

  task automatic offer(input logic [2:0] op, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    check("ready_before_accept", req_ready, 1'b1);
    req_valid = 1'b1;
    mem_op    = op;
    mem_size  = sz;
    addr      = a;
    wdata     = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Memory-path operation; stray rvalid is driven during every REQ cycle to show it is ignored.
  task automatic do_mem(input string tag, input logic [2:0] op, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input int gnt_delay,
                        input logic [31:0] rd, input logic err,
                        input logic exp_we, input logic [3:0] exp_be, input logic [31:0] exp_addr,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                        input logic exp_exc, input logic [5:0] exp_cause);
    offer(op, sz, a, wd);
    for (int i = 0; i <= gnt_delay; i++) begin
      check({tag, "_req"},   dmem_if.dmem_req, 1'b1);
      check({tag, "_we"},    dmem_if.dmem_we, exp_we);
      check({tag, "_be"},    dmem_if.dmem_be, exp_be);
      check({tag, "_addr"},  dmem_if.dmem_addr, exp_addr);
      check({tag, "_wdata"}, dmem_if.dmem_wdata, exp_wdata);
      check({tag, "_busy"},  req_ready, 1'b0);
      dmem_if.dmem_rvalid = 1'b1;
      dmem_if.dmem_rdata  = 32'hDEAD_BEEF;
      dmem_if.dmem_err    = 1'b1;
      dmem_if.dmem_gnt    = (i == gnt_delay);
      @(negedge clk);
    end
    dmem_if.dmem_gnt = 1'b0;
    check({tag, "_req_drop"}, dmem_if.dmem_req, 1'b0);
    check({tag, "_no_early_resp"}, resp_valid, 1'b0);
    dmem_if.dmem_rvalid = 1'b1;
    dmem_if.dmem_rdata  = rd;
    dmem_if.dmem_err    = err;
    @(negedge clk);
    idle_bus();
    check({tag, "_resp_valid"}, resp_valid, 1'b1);
    check({tag, "_rdata"},      resp_rdata, exp_rdata);
    check({tag, "_exc"},        lsu_exception, exp_exc);
    check({tag, "_cause"},      lsu_exception_cause, exp_cause);
    @(negedge clk);
    check({tag, "_pulse_end"},  resp_valid, 1'b0);
    check({tag, "_ready_back"}, req_ready, 1'b1);
  endtask

  task automatic do_early(input string tag, input logic [2:0] op, input logic [1:0] sz,
                          input logic [31:0] a, input logic exp_exc, input logic [5:0] exp_cause);
    offer(op, sz, a, 32'h1122_3344);
    check({tag, "_no_req"},     dmem_if.dmem_req, 1'b0);
    check({tag, "_resp_valid"}, resp_valid, 1'b1);
    check({tag, "_rdata"},      resp_rdata, 32'h0);
    check({tag, "_exc"},        lsu_exception, exp_exc);
    check({tag, "_cause"},      lsu_exception_cause, exp_cause);
    @(negedge clk);
    check({tag, "_pulse_end"},  resp_valid, 1'b0);
    check({tag, "_ready_back"}, req_ready, 1'b1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"},  req_ready, 1'b1);
    check({tag, "_req"},    dmem_if.dmem_req, 1'b0);
    check({tag, "_we"},     dmem_if.dmem_we, 1'b0);
    check({tag, "_be"},     dmem_if.dmem_be, 4'b0000);
    check({tag, "_addr"},   dmem_if.dmem_addr, 32'h0);
    check({tag, "_wdata"},  dmem_if.dmem_wdata, 32'h0);
    check({tag, "_rvalid"}, resp_valid, 1'b0);
    check({tag, "_rdata"},  resp_rdata, 32'h0);
    check({tag, "_exc"},    lsu_exception, 1'b0);
    check({tag, "_cause"},  lsu_exception_cause, 6'd0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    mem_op    = OP_NONE;
    mem_size  = SZ_B;
    addr      = 32'h0;
    wdata     = 32'h0;
    idle_bus();
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    do_mem("lb",  OP_LOAD,  SZ_B, 32'h0000_1003, 32'hFFFF_FFFF, 0, 32'h8000_0000, 1'b0,
           1'b0, 4'b1000, 32'h0000_1000, 32'h0, 32'hFFFF_FF80, 1'b0, 6'd0);
    do_mem("lhu", OP_LOADU, SZ_H, 32'h0000_2002, 32'h0, 0, 32'hBEEF_1234, 1'b0,
           1'b0, 4'b1100, 32'h0000_2000, 32'h0, 32'h0000_BEEF, 1'b0, 6'd0);
    do_mem("lh",  OP_LOAD,  SZ_H, 32'h0000_2002, 32'h0, 0, 32'hBEEF_1234, 1'b0,
           1'b0, 4'b1100, 32'h0000_2000, 32'h0, 32'hFFFF_BEEF, 1'b0, 6'd0);
    do_mem("lbu", OP_LOADU, SZ_B, 32'h0000_0001, 32'h0, 1, 32'h0000_F700, 1'b0,
           1'b0, 4'b0010, 32'h0000_0000, 32'h0, 32'h0000_00F7, 1'b0, 6'd0);
    do_mem("sb",  OP_STORE, SZ_B, 32'h0000_0011, 32'h0000_00A5, 0, 32'h1234_5678, 1'b0,
           1'b1, 4'b0010, 32'h0000_0010, 32'hA5A5_A5A5, 32'h0, 1'b0, 6'd0);
    do_mem("sh",  OP_STORE, SZ_H, 32'h0000_0006, 32'h1234_CAFE, 0, 32'h1234_5678, 1'b0,
           1'b1, 4'b1100, 32'h0000_0004, 32'hCAFE_CAFE, 32'h0, 1'b0, 6'd0);
    do_mem("lw_err", OP_LOAD, SZ_W, 32'h0000_3000, 32'h0, 3, 32'h5555_AAAA, 1'b1,
           1'b0, 4'b1111, 32'h0000_3000, 32'h0, 32'h0, 1'b1, 6'd5);
    do_mem("sw_err", OP_STORE, SZ_W, 32'h0000_0040, 32'h1122_3344, 0, 32'h0, 1'b1,
           1'b1, 4'b1111, 32'h0000_0040, 32'h1122_3344, 32'h0, 1'b1, 6'd7);

    do_early("sw_mis",  OP_STORE,   SZ_W, 32'h0000_0102, 1'b1, 6'd6);
    do_early("lh_mis",  OP_LOAD,    SZ_H, 32'h0000_0101, 1'b1, 6'd4);
    do_early("invalid", OP_INVALID, SZ_W, 32'h0000_0000, 1'b1, 6'd2);
    do_early("none",    OP_NONE,    SZ_W, 32'h0000_0000, 1'b0, 6'd0);

    // Reset while waiting for the response, then a stray rvalid.
    offer(OP_LOAD, SZ_W, 32'h0000_0008, 32'h0);
    dmem_if.dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_if.dmem_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("mid_rst");
    rst = 1'b0;
    dmem_if.dmem_rvalid = 1'b1;
    dmem_if.dmem_rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    idle_bus();
    check("stray_rvalid_resp", resp_valid, 1'b0);
    check("stray_rvalid_ready", req_ready, 1'b1);
    @(negedge clk);
    check("stray_rvalid_resp2", resp_valid, 1'b0);

    do_mem("lw_after_rst", OP_LOAD, SZ_W, 32'h0000_0008, 32'h0, 0, 32'h7654_3210, 1'b0,
           1'b0, 4'b1111, 32'h0000_0008, 32'h0, 32'h7654_3210, 1'b0, 6'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
